// File: rtl/dkong3_dma_pkg.sv
// rtl/dkong3_dma_pkg.sv - shared constants and state encoding for the sprite DMA sequencer
package dkong3_dma_pkg;

   localparam int ADDR_W = 10;

   localparam int               DEF_LEN      = 415;
   localparam logic [ADDR_W-1:0] DEF_SRC_BASE = 10'h100;
   localparam logic [ADDR_W-1:0] DEF_DST_BASE = 10'h000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/dkong3_dma_seq_if.sv
// rtl/dkong3_dma_seq_if.sv - trigger, 7H read port, object RAM write port and status bundle
interface dkong3_dma_seq_if;
   import dkong3_dma_pkg::*;

   logic              I_DMA_TRIG;
   logic              I_HOLD_n;
   logic [7:0]        I_DMA_DS;
   logic [ADDR_W-1:0] O_DMA_AS;
   logic              O_DMA_CES;
   logic [ADDR_W-1:0] O_DMA_AD;
   logic [7:0]        O_DMA_DD;
   logic              O_DMA_CED;
   logic              O_BUSY;
   logic              O_DONE;
   logic              O_WAIT_n;

   modport slave (
      input  I_DMA_TRIG, I_HOLD_n, I_DMA_DS,
      output O_DMA_AS, O_DMA_CES, O_DMA_AD, O_DMA_DD, O_DMA_CED,
             O_BUSY, O_DONE, O_WAIT_n
   );

   modport master (
      output I_DMA_TRIG, I_HOLD_n, I_DMA_DS,
      input  O_DMA_AS, O_DMA_CES, O_DMA_AD, O_DMA_DD, O_DMA_CED,
             O_BUSY, O_DONE, O_WAIT_n
   );

endinterface

// File: rtl/dkong3_edge_det.sv
// rtl/dkong3_edge_det.sv - rising-edge detector, async active-low reset
module dkong3_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/dkong3_dma_seq.sv
// rtl/dkong3_dma_seq.sv - sprite DMA sequencer copying 7H into object RAM, one byte per clock
// Optional CPU stall during the copy: define DKONG3_DMA_WAIT_EN.
module dkong3_dma_seq
   import dkong3_dma_pkg::*;
#(
   parameter int               LEN      = DEF_LEN,
   parameter logic [ADDR_W-1:0] SRC_BASE = DEF_SRC_BASE,
   parameter logic [ADDR_W-1:0] DST_BASE = DEF_DST_BASE
) (
   input  logic             I_CLK,
   input  logic             I_RESET_n,
   dkong3_dma_seq_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

   dma_state_t        state, state_d;
   logic [ADDR_W-1:0] cnt, cnt_d, cnt_q;
   logic              pending, pending_d;
   logic              valid_q;
   logic              ces;
   logic              start;

   dkong3_edge_det u_trig (
      .clk   (I_CLK),
      .rst_n (I_RESET_n),
      .d     (bus.I_DMA_TRIG),
      .rise  (start)
   );

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         pending <= pending_d;
         valid_q <= ces;
         cnt_q   <= cnt;
      end
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      pending_d = pending;
      ces       = 1'b0;
      // Any number of edges during a transfer collapse into a single pending request.
      if (start && state != ST_IDLE) pending_d = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (bus.I_HOLD_n) begin
               ces   = 1'b1;
               cnt_d = cnt + 10'd1;
               if (cnt == LAST) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE: begin
            if (pending || start) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               pending_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Address/data buses are forced to zero whenever their strobe is idle.
   assign bus.O_DMA_CES = ces;
   assign bus.O_DMA_AS  = ces ? SRC_BASE + cnt : '0;
   assign bus.O_DMA_CED = valid_q;
   assign bus.O_DMA_AD  = valid_q ? DST_BASE + cnt_q : '0;
   assign bus.O_DMA_DD  = valid_q ? bus.I_DMA_DS : 8'h00;
   assign bus.O_BUSY    = (state == ST_RUN) || (state == ST_FLUSH);
   assign bus.O_DONE    = (state == ST_DONE);

`ifdef DKONG3_DMA_WAIT_EN
   logic wait_q;

   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n) wait_q <= 1'b1;
      else            wait_q <= ~((state_d == ST_RUN) || (state_d == ST_FLUSH));
   end

   assign bus.O_WAIT_n = wait_q;
`else
   assign bus.O_WAIT_n = 1'b1;
`endif

endmodule

// File: tb/tb_dkong3_dma_seq.sv
// tb/tb_dkong3_dma_seq.sv - directed self-checking bench for dkong3_dma_seq
`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_dkong3_dma_seq;
   import dkong3_dma_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   k = 0;

   int   writes = 0, reads = 0, busy_cnt = 0, done_cnt = 0, last_done = 0;
   int   wr_bad = 0, wait_bad = 0, wr_idx = 0;
   logic mon_clr = 1'b0;
   logic exp_wait;

   dkong3_dma_seq_if bus0 ();
   dkong3_dma_seq_if bus1 ();

   dkong3_dma_seq u0 (
      .I_CLK     (clk),
      .I_RESET_n (rst_n),
      .bus       (bus0)
   );

   dkong3_dma_seq #(.LEN(1)) u1 (
      .I_CLK     (clk),
      .I_RESET_n (rst_n),
      .bus       (bus1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // 7H models: src[i] = i for u0, a scrambled byte for u1
   always @(posedge clk) if (bus0.O_DMA_CES) bus0.I_DMA_DS <= 8'(bus0.O_DMA_AS - 10'h100);
   always @(posedge clk) if (bus1.O_DMA_CES) bus1.I_DMA_DS <= bus1.O_DMA_AS[7:0] ^ 8'h5A;

`ifdef DKONG3_DMA_WAIT_EN
   assign exp_wait = ~bus0.O_BUSY;
`else
   assign exp_wait = 1'b1;
`endif

   always @(negedge clk) begin
      if (mon_clr) begin
         writes <= 0; reads <= 0; busy_cnt <= 0; done_cnt <= 0;
         last_done <= 0; wr_bad <= 0; wr_idx <= 0;
      end else begin
         if (bus0.O_DMA_CED) begin
            writes <= writes + 1;
            if (bus0.O_DMA_AD !== wr_idx[9:0] || bus0.O_DMA_DD !== wr_idx[7:0])
               wr_bad <= wr_bad + 1;
            wr_idx <= (wr_idx == 414) ? 0 : wr_idx + 1;
         end
         if (bus0.O_DMA_CES) reads <= reads + 1;
         if (bus0.O_BUSY) busy_cnt <= busy_cnt + 1;
         if (bus0.O_DONE) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc + 1;
         end
      end
      if (bus0.O_WAIT_n !== exp_wait) wait_bad <= wait_bad + 1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      mon_clr = 1'b1;
      step(1);
      mon_clr = 1'b0;
   endtask

   task automatic wait_done(input int target, input int bound);
      int t = 0;
      while (done_cnt < target && t < bound) begin
         step(1);
         t++;
      end
      `CHK("done_timeout", (done_cnt >= target), 1'b1)
   endtask

   initial begin
      bus0.I_DMA_TRIG = 1'b0; bus0.I_HOLD_n = 1'b1;
      bus1.I_DMA_TRIG = 1'b0; bus1.I_HOLD_n = 1'b1;
      rst_n = 1'b0;
      step(3);
      `CHK("rst_ces",  bus0.O_DMA_CES, 1'b0)
      `CHK("rst_ced",  bus0.O_DMA_CED, 1'b0)
      `CHK("rst_busy", bus0.O_BUSY,    1'b0)
      `CHK("rst_done", bus0.O_DONE,    1'b0)
      `CHK("rst_as",   bus0.O_DMA_AS,  10'h000)
      `CHK("rst_ad",   bus0.O_DMA_AD,  10'h000)
      `CHK("rst_dd",   bus0.O_DMA_DD,  8'h00)
      `CHK("rst_wait", bus0.O_WAIT_n,  1'b1)
      rst_n = 1'b1;
      step(2);

      // basic transfer
      clear_stats();
      bus0.I_DMA_TRIG = 1'b1;
      k = cyc + 1;
      step(1);
      `CHK("t1_first_ces", bus0.O_DMA_CES, 1'b1)
      `CHK("t1_first_as",  bus0.O_DMA_AS,  10'h100)
      step(3);
      bus0.I_DMA_TRIG = 1'b0;
      wait_done(1, 1000);
      `CHK("t1_writes",    writes,    415)
      `CHK("t1_reads",     reads,     415)
      `CHK("t1_wr_bad",    wr_bad,    0)
      `CHK("t1_done_edge", last_done, k + 417)
      `CHK("t1_busy",      busy_cnt,  416)
      step(3);
      `CHK("t1_one_done",  done_cnt,  1)
      `CHK("t1_idle",      bus0.O_BUSY, 1'b0)

      // hold for 5 clocks at read #10
      clear_stats();
      bus0.I_DMA_TRIG = 1'b1;
      k = cyc + 1;
      step(11);
      bus0.I_HOLD_n = 1'b0;
      bus0.I_DMA_TRIG = 1'b0;
      step(5);
      `CHK("t2_reads_held",  reads,  10)
      `CHK("t2_writes_held", writes, 10)
      bus0.I_HOLD_n = 1'b1;
      #1;
      `CHK("t2_resume_ces", bus0.O_DMA_CES, 1'b1)
      `CHK("t2_resume_as",  bus0.O_DMA_AS,  10'h10A)
      wait_done(1, 1000);
      `CHK("t2_writes",    writes,    415)
      `CHK("t2_wr_bad",    wr_bad,    0)
      `CHK("t2_done_edge", last_done, k + 422)
      `CHK("t2_busy",      busy_cnt,  421)
      step(3);

      // two retrigger edges collapse into one back-to-back transfer
      clear_stats();
      bus0.I_DMA_TRIG = 1'b1;
      k = cyc + 1;
      step(2);  bus0.I_DMA_TRIG = 1'b0;
      step(50); bus0.I_DMA_TRIG = 1'b1;
      step(2);  bus0.I_DMA_TRIG = 1'b0;
      step(50); bus0.I_DMA_TRIG = 1'b1;
      step(2);  bus0.I_DMA_TRIG = 1'b0;
      wait_done(2, 2000);
      `CHK("t3_writes",    writes,    830)
      `CHK("t3_wr_bad",    wr_bad,    0)
      `CHK("t3_done_edge", last_done, k + 834)
      `CHK("t3_busy",      busy_cnt,  832)
      step(5);
      `CHK("t3_done_cnt",  done_cnt,  2)
      `CHK("t3_idle",      bus0.O_BUSY, 1'b0)

      // async reset at write #100, then restart
      clear_stats();
      bus0.I_DMA_TRIG = 1'b1;
      k = cyc + 1;
      step(102);
      bus0.I_DMA_TRIG = 1'b0;
      `CHK("t4_pre_ced", bus0.O_DMA_CED, 1'b1)
      `CHK("t4_pre_ad",  bus0.O_DMA_AD,  10'd100)
      #2 rst_n = 1'b0;
      #1;
      `CHK("t4_rst_ces",  bus0.O_DMA_CES, 1'b0)
      `CHK("t4_rst_ced",  bus0.O_DMA_CED, 1'b0)
      `CHK("t4_rst_busy", bus0.O_BUSY,    1'b0)
      `CHK("t4_rst_done", bus0.O_DONE,    1'b0)
      `CHK("t4_rst_as",   bus0.O_DMA_AS,  10'h000)
      step(2);
      rst_n = 1'b1;
      step(1);
      clear_stats();
      bus0.I_DMA_TRIG = 1'b1;
      step(1);
      `CHK("t4_restart_ces", bus0.O_DMA_CES, 1'b1)
      `CHK("t4_restart_as",  bus0.O_DMA_AS,  10'h100)
      step(2);
      bus0.I_DMA_TRIG = 1'b0;
      wait_done(1, 1000);
      `CHK("t4_writes", writes, 415)
      `CHK("t4_wr_bad", wr_bad, 0)

      // LEN=1 instance
      bus1.I_DMA_TRIG = 1'b1;
      step(1);
      `CHK("t5_ces",   bus1.O_DMA_CES, 1'b1)
      `CHK("t5_as",    bus1.O_DMA_AS,  10'h100)
      `CHK("t5_busy",  bus1.O_BUSY,    1'b1)
      step(1);
      `CHK("t5_ces_off", bus1.O_DMA_CES, 1'b0)
      `CHK("t5_ced",   bus1.O_DMA_CED, 1'b1)
      `CHK("t5_ad",    bus1.O_DMA_AD,  10'h000)
      `CHK("t5_dd",    bus1.O_DMA_DD,  8'h5A)
      step(1);
      `CHK("t5_done",  bus1.O_DONE,    1'b1)
      `CHK("t5_nbusy", bus1.O_BUSY,    1'b0)
      step(1);
      `CHK("t5_done_off", bus1.O_DONE, 1'b0)
      bus1.I_DMA_TRIG = 1'b0;

      step(2);
      `CHK("wait_track", wait_bad, 0)

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`undef CHK

// File: doc/dkong3_dma_seq.md
Name: dkong3_dma_seq

Overview:
- Sequencer for the sprite DMA datapath. It copies the CPU sprite table in work RAM 7H (port B, read-only) into object RAM.
- A rising edge on the 3E latch DMA bit starts a fixed-length block copy.
- Pipelined to one byte per clock after a one-cycle fill. Supports a hold/pause handshake and a pending retrigger.
- Replaces the free-running DMA engine and gives it defined busy, done and wait semantics.

Parameters:
- LEN, 415 (0x19F): bytes per transfer, 1..1023.
- SRC_BASE, 10'h100: source start address in 7H, i.e. CPU $6900.
- DST_BASE, 10'h000: destination start address in object RAM.

Ports:
- I_CLK  in  1  sequencer clock (inverted CPU clock domain).
- I_RESET_n  in  1  asynchronous active-low reset.
- I_DMA_TRIG  in  1  level from 3E Q5; a rising edge requests a transfer.
- I_HOLD_n  in  1  low = pause issuing reads (object RAM in use by video).
- I_DMA_DS  in  8  7H port-B read data, valid 1 clock after O_DMA_CES/O_DMA_AS.
- O_DMA_AS  out  10  source address.
- O_DMA_CES  out  1  source read enable.
- O_DMA_AD  out  10  destination address.
- O_DMA_DD  out  8  destination data.
- O_DMA_CED  out  1  destination write enable.
- O_BUSY  out  1  transfer in progress.
- O_DONE  out  1  one-clock pulse when a transfer completes.
- O_WAIT_n  out  1  CPU wait request (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 except O_WAIT_n=1. State IDLE, counter 0, pending flag 0, edge-detect register 0. Reset mid-transfer aborts immediately; no further CE on either port.
- Edge detect: trig_q <= I_DMA_TRIG; start = I_DMA_TRIG & ~trig_q.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: if start, go to RUN; cnt=0.
- RUN, I_HOLD_n=1:
  - O_DMA_CES=1, O_DMA_AS=SRC_BASE+cnt; cnt++.
  - When cnt reaches LEN-1 on this issue, go to FLUSH.
- RUN, I_HOLD_n=0: O_DMA_CES=0 and cnt frozen. An already-issued read still completes its write next clock.
- Write stage: registered valid/addr follow each issued read by 1 clock. O_DMA_CED=valid_q, O_DMA_AD=DST_BASE+cnt_q, O_DMA_DD=I_DMA_DS.
- FLUSH: final write occurs; go to DONE. I_HOLD_n has no effect in FLUSH.
- DONE: O_DONE=1 for one clock. Go to RUN (cnt=0) if pending is set and clear pending; otherwise go to IDLE.
- Timing: with the start edge sampled at clock k and no hold:
  - first read at k+1, first write at k+2;
  - last read at k+LEN, last write at k+LEN+1;
  - O_DONE at k+LEN+2.
- O_BUSY=1 in RUN and FLUSH.
- Retrigger: a start while not IDLE sets pending. Multiple edges collapse to one pending transfer. A start in the same clock as DONE also sets pending and is honoured.
- Address arithmetic is 10-bit modulo; wrap past 10'h3FF is permitted, not flagged.
- LEN=1: the single read in RUN goes directly to FLUSH.

Optional Feature:
- Macro DKONG3_DMA_WAIT_EN.
- Defined: O_WAIT_n = ~O_BUSY, registered with the state, so the main CPU stalls during the copy.
- Undefined: O_WAIT_n tied 1; the CPU runs concurrently.

Decomposition:
- Package dkong3_dma_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3);
  - default LEN/SRC_BASE/DST_BASE values;
  - address width constant 10.
- One sub-module, dkong3_edge_det: rising-edge detector with asynchronous active-low reset, reused for the trigger.

Test Plan:
- Reset then trigger 0→1, memory model src[i]=i[7:0] -> 415 writes, AD 0x000..0x19E, DD=0x00..0x9E wrapping per 8 bits. O_DONE at k+417. O_BUSY high exactly 416 clocks.
- I_HOLD_n low for 5 clocks starting at read #10 -> read #9's write still occurs; no CES for 5 clocks. Resume at AS=0x10A; total writes 415; O_DONE delayed by 5.
- Two extra trigger edges mid-transfer -> exactly one additional back-to-back transfer (DONE, then RUN next clock). Total 830 writes, two O_DONE pulses.
- I_RESET_n asserted at write #100 -> all CE/BUSY/DONE drop to 0 asynchronously; a fresh trigger restarts at AS=0x100.
- LEN=1 override -> one read at 0x100, one write at 0x000, O_DONE at k+3.
- DKONG3_DMA_WAIT_EN defined -> O_WAIT_n low for exactly the O_BUSY window. Undefined -> O_WAIT_n constant 1.
